// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM states and datapath widths.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package intc_pkg;

  localparam int VEC_W = 32;  // handler vector width
  localparam int ID_W  = 4;   // request id width (up to 16 maskable sources)

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2,
    ST_NEST    = 2'd3
  } state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-bit 2-flop synchroniser followed by a registered rising-edge detector.
// Latency: input high sampled at edge k gives a one-cycle rise pulse after edge k+1.
// Backpressure: none; every pin edge produces exactly one pulse.
//
// Ports:
//   clk   in  1  clock, rising edge
//   rst_n in  1  asynchronous active-low reset
//   din   in  W  asynchronous input pins
//   rise  out W  one-cycle pulse per synchronised rising edge
module irq_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic [W-1:0] sync_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else begin
      sync1     <= din;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign rise = sync2 & ~sync_prev;

endmodule

// File: rtl/interrupt_controller.sv
// Prioritising interrupt controller: N_IRQ maskable edge IRQs plus one NMI, one request at a time.
// Latency: pin edge -> pending after 2 clocks; pending -> int_req one clock after a boundary pulse.
// Backpressure: int_req is held with a frozen vector/id until int_ack; no timeout.
//
// Optional feature macro: INTC_NMI_NEST_EN (NMI may preempt a maskable handler, depth 1).
//
// Ports:
//   clk, rst_n               clock and asynchronous active-low reset
//   irq[N_IRQ], nmi          asynchronous rising-edge requests
//   intd                     global maskable disable (NMI unaffected)
//   mask_we, mask_wdata      mask register write (1 = source enabled)
//   boundary                 CPU is at an instruction boundary and may take a request
//   int_ack, eret            CPU accepted the request / handler finished
//   int_req, vector, irq_id, is_nmi   current request to the CPU
//   in_service               a handler is active
//   pending                  raw pending bits
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int               N_IRQ      = 8,
  parameter logic [VEC_W-1:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [VEC_W-1:0] VEC_STRIDE = 32'h0000_0010,
  parameter logic [VEC_W-1:0] NMI_VEC    = 32'h0000_0080,
  parameter logic [N_IRQ-1:0] MASK_RST   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq,
  input  logic             nmi,
  input  logic             intd,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             boundary,
  input  logic             int_ack,
  input  logic             eret,
  output logic             int_req,
  output logic [VEC_W-1:0] vector,
  output logic [ID_W-1:0]  irq_id,
  output logic             is_nmi,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending
);

  state_t           state;
  logic [N_IRQ-1:0] mask;
  logic             nmi_pend;
  logic [N_IRQ-1:0] irq_rise;
  logic             nmi_rise;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] clr;
  logic             any_elig;
  logic [ID_W-1:0]  win_id;
  logic [VEC_W-1:0] win_vec;
  logic             req_ack;

`ifdef INTC_NMI_NEST_EN
  logic             nested;    // current REQ is an NMI preempting a maskable handler
  logic [ID_W-1:0]  saved_id;  // id of the preempted maskable handler
`endif

  irq_sync_edge #(.W(N_IRQ)) u_irq_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (irq),
    .rise  (irq_rise)
  );

  irq_sync_edge #(.W(1)) u_nmi_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (nmi),
    .rise  (nmi_rise)
  );

  assign eligible = intd ? '0 : (pending & mask);
  assign any_elig = |eligible;
  assign req_ack  = (state == ST_REQ) && int_ack;

  // Lowest index wins: scanning downward leaves the smallest set index last.
  always_comb begin
    win_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

  // Truncation to 32 bits gives the required mod 2^32 wrap.
  assign win_vec = VEC_BASE + VEC_STRIDE * VEC_W'(win_id);

  // Acked maskable id clears its pending bit; a fresh edge in the same cycle is kept.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clr[i] = req_ack && !is_nmi && (irq_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      nmi_pend <= 1'b0;
      mask     <= MASK_RST;
    end else begin
      pending  <= (pending & ~clr) | irq_rise;
      nmi_pend <= (nmi_pend & ~(req_ack & is_nmi)) | nmi_rise;
      if (mask_we) mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      int_req    <= 1'b0;
      vector     <= '0;
      irq_id     <= '0;
      is_nmi     <= 1'b0;
      in_service <= 1'b0;
`ifdef INTC_NMI_NEST_EN
      nested     <= 1'b0;
      saved_id   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (boundary) begin
            if (nmi_pend) begin
              state   <= ST_REQ;
              int_req <= 1'b1;
              vector  <= NMI_VEC;
              irq_id  <= '0;
              is_nmi  <= 1'b1;
            end else if (any_elig) begin
              state   <= ST_REQ;
              int_req <= 1'b1;
              vector  <= win_vec;
              irq_id  <= win_id;
              is_nmi  <= 1'b0;
            end
          end
        end

        // Request fields are frozen here; only int_ack moves on (eret is ignored).
        ST_REQ: begin
          if (int_ack) begin
            int_req    <= 1'b0;
            in_service <= 1'b1;
`ifdef INTC_NMI_NEST_EN
            state      <= nested ? ST_NEST : ST_SERVICE;
            nested     <= 1'b0;
`else
            state      <= ST_SERVICE;
`endif
          end
        end

        ST_SERVICE: begin
          if (eret) begin
            state      <= ST_IDLE;
            in_service <= 1'b0;
            is_nmi     <= 1'b0;
            irq_id     <= '0;
          end
`ifdef INTC_NMI_NEST_EN
          else if (boundary && nmi_pend && !is_nmi) begin
            // in_service stays high: the maskable handler is still live underneath.
            state    <= ST_REQ;
            int_req  <= 1'b1;
            vector   <= NMI_VEC;
            saved_id <= irq_id;
            irq_id   <= '0;
            is_nmi   <= 1'b1;
            nested   <= 1'b1;
          end
`endif
        end

        ST_NEST: begin
`ifdef INTC_NMI_NEST_EN
          if (eret) begin
            state  <= ST_SERVICE;
            irq_id <= saved_id;
            is_nmi <= 1'b0;
          end
`else
          // Unreachable without nesting; recover to a safe state.
          state <= ST_IDLE;
`endif
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: scoreboard of expected requests plus status checks.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_interrupt_controller;

  logic        clk;
  logic        rst_n;
  logic [7:0]  irq;
  logic        nmi;
  logic        intd;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic        boundary;
  logic        int_ack;
  logic        eret;
  logic        int_req;
  logic [31:0] vector;
  logic [3:0]  irq_id;
  logic        is_nmi;
  logic        in_service;
  logic [7:0]  pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        nmi;
    logic [3:0]  id;
    logic [31:0] vec;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_req = 1'b0;
  logic [31:0] held_vec = '0;

  interrupt_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq        (irq),
    .nmi        (nmi),
    .intd       (intd),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .boundary   (boundary),
    .int_ack    (int_ack),
    .eret       (eret),
    .int_req    (int_req),
    .vector     (vector),
    .irq_id     (irq_id),
    .is_nmi     (is_nmi),
    .in_service (in_service),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Scoreboard side: every rising int_req pops one expectation; vector must hold until ack.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (int_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          check("unexp_req", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("req_nmi", 32'(is_nmi), 32'(mon_e.nmi));
          check("req_id", 32'(irq_id), 32'(mon_e.id));
          check("req_vec", vector, mon_e.vec);
          held_vec = mon_e.vec;
        end
      end else if (int_req) begin
        check("vec_hold", vector, held_vec);
      end
      prev_req = int_req;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_irq(input int idx);
    @(negedge clk);
    irq[idx] = 1'b1;
    @(negedge clk);
    irq[idx] = 1'b0;
    wait_cyc(3);
  endtask

  task automatic pulse_nmi();
    @(negedge clk);
    nmi = 1'b1;
    @(negedge clk);
    nmi = 1'b0;
    wait_cyc(3);
  endtask

  task automatic set_mask(input logic [7:0] m);
    @(negedge clk);
    mask_we    = 1'b1;
    mask_wdata = m;
    @(negedge clk);
    mask_we    = 1'b0;
  endtask

  task automatic do_boundary();
    @(negedge clk);
    boundary = 1'b1;
    @(negedge clk);
    boundary = 1'b0;
  endtask

  // Push the expected request, give a boundary, and wait (bounded) for the monitor to consume it.
  task automatic take(input logic e_nmi, input logic [3:0] e_id, input logic [31:0] e_vec);
    exp_t e;
    int   n;
    e.nmi = e_nmi;
    e.id  = e_id;
    e.vec = e_vec;
    exp_q.push_back(e);
    do_boundary();
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("req_timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic ack();
    @(negedge clk);
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    check("ack_req_low", 32'(int_req), 32'd0);
    check("ack_insvc", 32'(in_service), 32'd1);
  endtask

  task automatic do_eret(input logic exp_insvc);
    @(negedge clk);
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    check("eret_insvc", 32'(in_service), 32'(exp_insvc));
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; nmi = 1'b0; intd = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    boundary = 1'b0; int_ack = 1'b0; eret = 1'b0;
    wait_cyc(3);
    check("rst_int_req", 32'(int_req), 32'd0);
    check("rst_vector", vector, 32'd0);
    check("rst_irq_id", 32'(irq_id), 32'd0);
    check("rst_is_nmi", 32'(is_nmi), 32'd0);
    check("rst_insvc", 32'(in_service), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    rst_n = 1'b1;
    wait_cyc(2);

    // 1: priority among two pending, then the lower-priority one afterwards
    set_mask(8'h0C);
    pulse_irq(3);
    pulse_irq(2);
    check("t1_pending", 32'(pending), 32'h0C);
    take(1'b0, 4'd2, 32'h120);
    ack();
    check("t1_pend_after", 32'(pending), 32'h08);
    do_eret(1'b0);
    take(1'b0, 4'd3, 32'h130);
    ack();
    do_eret(1'b0);

    // 2: intd blocks maskable requests, pending retained
    set_mask(8'hFF);
    intd = 1'b1;
    pulse_irq(0);
    do_boundary();
    wait_cyc(2);
    check("t2_no_req", 32'(int_req), 32'd0);
    check("t2_pending", 32'(pending), 32'h01);
    intd = 1'b0;
    take(1'b0, 4'd0, 32'h100);
    ack();
    do_eret(1'b0);

    // 3: NMI beats a simultaneous maskable request
    @(negedge clk);
    nmi = 1'b1; irq[1] = 1'b1;
    @(negedge clk);
    nmi = 1'b0; irq[1] = 1'b0;
    wait_cyc(3);
    take(1'b1, 4'd0, 32'h80);
    ack();
    do_eret(1'b0);
    take(1'b0, 4'd1, 32'h110);
    ack();
    do_eret(1'b0);

    // 4: NMI arriving during a maskable handler
    pulse_irq(4);
    take(1'b0, 4'd4, 32'h140);
    ack();
    pulse_nmi();
`ifdef INTC_NMI_NEST_EN
    take(1'b1, 4'd0, 32'h80);
    ack();
    check("t4_nest_nmi", 32'(is_nmi), 32'd1);
    do_eret(1'b1);
    check("t4_restore_id", 32'(irq_id), 32'd4);
    check("t4_restore_nmi", 32'(is_nmi), 32'd0);
    do_eret(1'b0);
`else
    do_boundary();
    wait_cyc(2);
    check("t4_no_nest", 32'(int_req), 32'd0);
    do_eret(1'b0);
    take(1'b1, 4'd0, 32'h80);
    ack();
    do_eret(1'b0);
`endif

    // 5: latched request survives a mask write
    pulse_irq(5);
    take(1'b0, 4'd5, 32'h150);
    set_mask(8'h00);
    wait_cyc(3);
    check("t5_req_held", 32'(int_req), 32'd1);
    check("t5_vec_held", vector, 32'h150);
    ack();
    do_eret(1'b0);

    // merge of two edges; int_ack outside REQ ignored
    pulse_irq(6);
    pulse_irq(6);
    pulse_irq(7);
    @(negedge clk);
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    check("idle_ack_ign", 32'(pending), 32'hC0);
    set_mask(8'hFF);
    take(1'b0, 4'd6, 32'h160);
    ack();
    do_eret(1'b0);
    take(1'b0, 4'd7, 32'h170);
    ack();
    do_eret(1'b0);
    do_boundary();
    wait_cyc(2);
    check("merge_none", 32'(int_req), 32'd0);
    check("merge_pend", 32'(pending), 32'h00);

    // 6: reset during REQ
    pulse_irq(5);
    pulse_irq(2);
    take(1'b0, 4'd2, 32'h120);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_req", 32'(int_req), 32'd0);
    check("t6_pending", 32'(pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_irq(1);
    check("t6_pend_new", 32'(pending), 32'h02);
    do_boundary();
    wait_cyc(2);
    check("t6_mask_rst", 32'(int_req), 32'd0);
    check("q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
